ami_channel_arbiter: RTL
========================

# ami_channel_arbiter

Round-robin arbiter that shares one SimpleDRAM channel among `NUM_REQ` requester ports of the AmorphOS memory system. It sits between the per-app/per-port request side and one `SimSimpleDram`/SimpleDRAM channel, carrying `MemReq`/`MemResp` structs. An in-order tag FIFO routes each read response back to the requester that issued the read. It also keeps per-requester outstanding-read counters and a sticky error flag.

## Interface
- `NUM_REQ`, 4 — number of requester ports (≥2).
- `LOG_TAG_DEPTH`, 4 — tag FIFO depth is 2^LOG_TAG_DEPTH (16). This is the maximum number of reads in flight on the channel.
- `CNT_W`, 8 — width of each outstanding-read counter.

Ports:
- `clk` in 1 — clock.
- `rst` in 1 — reset, asynchronous, active-high.
- `req_enable` in [NUM_REQ] — per-requester enable. A disabled requester is never selected.
- `req_in` in MemReq[NUM_REQ] — requests (valid, isWrite, addr, data).
- `req_grant_out` out [NUM_REQ] — request accepted this cycle.
- `resp_out` out MemResp[NUM_REQ] — routed read responses.
- `resp_grant_in` in [NUM_REQ] — requester consumes its response.
- `ch_req_out` out MemReq — request to the channel.
- `ch_req_grant_in` in 1 — channel accepts `ch_req_out`.
- `ch_resp_in` in MemResp — response from the channel.
- `ch_resp_grant_out` out 1 — response consumed.
- `outstanding` out [NUM_REQ][CNT_W] — reads issued but not yet returned, per requester.
- `orphan_err` out 1 — sticky flag: a response arrived with the tag FIFO empty.

## Operation
- **Eligibility.** Requester i is eligible when `req_enable[i]` and `req_in[i].valid` are both set. For a read, the tag FIFO must also be not full (registered `full`). A write is eligible regardless of FIFO state.
- **Selection.** Pick the first eligible index scanning `rr_ptr, rr_ptr+1, …` modulo NUM_REQ.
- **Request drive.**
  - With a selection: `ch_req_out = req_in[sel]` with valid=1.
  - With no selection: `ch_req_out.valid=0` and other fields don't-care.
- **Request grant.** `req_grant_out[sel] = ch_req_grant_in`. All other grants are 0.
- **Transfer** = `ch_req_out.valid & ch_req_grant_in`. On a transfer:
  - `rr_ptr <= (sel+1) mod NUM_REQ`.
  - If it is a read, push `sel` into the tag FIFO and increment `outstanding[sel]`.
- **rr_ptr hold.** `rr_ptr` holds when there is no transfer. A stalled channel therefore keeps the same winner unless that winner drops valid.
- **Response routing.** With FIFO not empty, let `h` = head tag.
  - `resp_out[h] = ch_resp_in`. Every other `resp_out[j].valid = 0`.
  - `ch_resp_grant_out = resp_grant_in[h]`.
  - Pop and decrement `outstanding[h]` when `ch_resp_in.valid & resp_grant_in[h]`.
- **Orphan response.** If `ch_resp_in.valid` with FIFO empty: `ch_resp_grant_out=1` (drain/drop), no `resp_out` valid, `orphan_err <= 1` (cleared only by `rst`).
- **Same-cycle push and pop.** Both happen, and occupancy is unchanged. Push eligibility uses `full` from before the pop, so a full FIFO rejects a read even in a pop cycle.
- **Counters.** Counters saturate at 2^CNT_W−1 and never decrement below 0. One requester may increment and decrement in the same cycle; net change is 0.

## Timing
- The request and response paths are combinational, with zero-cycle pass-through. All state updates at posedge `clk`.
- **State.** `rr_ptr`, tag FIFO (head, tail, count), `outstanding`, `orphan_err`.
- **Reset values (async, immediate on `rst`).**
  - `rr_ptr=0`, FIFO empty.
  - All `outstanding=0`, `orphan_err=0`.
  - All `req_grant_out=0`, all `resp_out.valid=0`.
  - `ch_req_out.valid=0`, `ch_resp_grant_out=0`.
- **Throughput.** One request per cycle when the channel grants every cycle, and one response per cycle.
- **Reset during operation.** In-flight reads lose their tags. Their later responses are dropped as orphans and set `orphan_err`.
- **Response ordering.** The channel returns responses in request order, so tag order is FIFO order.
- **Grant dependency.** `ch_req_grant_in` must not combinationally depend on `ch_req_out`. The same applies to `resp_grant_in` and `resp_out`.

## Test plan
1. **Fairness.** All 4 requesters hold valid writes and the channel always grants. Grants must go 0,1,2,3,0,1,… with one per cycle; 8 cycles give exactly 2 grants each.
2. **Read routing.** Req0 writes 0xDEAD0000+i to addr i*64 and req1 writes 0xBEEF0000+i to addr 4096+i*128, for i=0..7. Both then read back interleaved. Each `resp_out[r].data[31:0]` must match its own written value, in order. `outstanding` must return to 0.
3. **FIFO full.** Issue 16 reads with `resp_grant_in=0`. The 17th read must not be granted while a concurrent write from another requester is granted. One pop then lets the 17th read issue, and `outstanding` totals 16.
4. **Channel stall and disable.**
   - Hold `ch_req_grant_in=0` for 5 cycles: no grants, and `rr_ptr` does not change.
   - Clear `req_enable[2]` with req2 valid: req2 never receives a grant.
5. **Orphan and reset.**
   - Issue 3 reads, pulse `rst` for 1 cycle, then the channel returns 3 responses. All 3 must be drained with `ch_resp_grant_out=1`, with no `resp_out` valid.
   - `orphan_err` rises after the first of these responses and stays 1.
   - All counters read 0 after `rst`.
6. **Same-cycle push/pop at full.** With the FIFO at 16, a pop coincides with a read request. The read must not be granted that cycle, the count goes to 15, and the read is granted next cycle.

Source files
------------

// File: rtl/ami_channel_arbiter.sv
// Round-robin arbiter sharing one SimpleDRAM channel among NUM_REQ requesters.
// Read responses are routed back through an in-order tag FIFO; per-requester
// outstanding-read counters and a sticky orphan-response flag are kept alongside.

package ami_mem_pkg;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;

    typedef struct packed {
        logic              valid;
        logic              is_write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_req_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
    } mem_resp_t;
endpackage

module ami_channel_arbiter
    import ami_mem_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int LOG_TAG_DEPTH = 4,
    parameter int CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_enable,
    input  mem_req_t           req_in [NUM_REQ],
    output logic [NUM_REQ-1:0] req_grant_out,
    output mem_resp_t          resp_out [NUM_REQ],
    input  logic [NUM_REQ-1:0] resp_grant_in,
    output mem_req_t           ch_req_out,
    input  logic               ch_req_grant_in,
    input  mem_resp_t          ch_resp_in,
    output logic               ch_resp_grant_out,
    output logic [CNT_W-1:0]   outstanding [NUM_REQ],
    output logic               orphan_err
);

    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DEPTH = 1 << LOG_TAG_DEPTH;

    typedef logic [SEL_W-1:0]         sel_t;
    typedef logic [LOG_TAG_DEPTH-1:0] ptr_t;
    typedef logic [LOG_TAG_DEPTH:0]   cnt_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    sel_t             rr_ptr_q, rr_ptr_d;
    sel_t             tag_mem_q [DEPTH];
    sel_t             tag_mem_d [DEPTH];
    ptr_t             head_q, head_d;
    ptr_t             tail_q, tail_d;
    cnt_t             count_q, count_d;
    logic [CNT_W-1:0] outstanding_q [NUM_REQ];
    logic [CNT_W-1:0] outstanding_d [NUM_REQ];
    logic             orphan_err_q, orphan_err_d;

    logic               fifo_full;
    logic               fifo_empty;
    sel_t               head_tag;
    logic [NUM_REQ-1:0] eligible;
    logic               sel_found;
    sel_t               sel;
    sel_t               cand;
    int                 idx;
    logic               transfer;
    logic               push;
    logic               pop;
    logic               orphan_seen;
    logic               inc;
    logic               dec;

    assign fifo_full  = (count_q == cnt_t'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head_tag   = tag_mem_q[head_q];

    // Find the first eligible requester scanning from rr_ptr; reads also need tag space.
    always_comb begin
        eligible  = '0;
        sel_found = 1'b0;
        sel       = rr_ptr_q;
        cand      = '0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = !rst && req_enable[i] && req_in[i].valid &&
                          (req_in[i].is_write || !fifo_full);
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = sel_t'(idx);
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel       = cand;
            end
        end
    end

    // Pass the winner straight through to the channel and return its grant.
    always_comb begin
        ch_req_out    = '0;
        req_grant_out = '0;
        if (sel_found) begin
            ch_req_out       = req_in[sel];
            ch_req_out.valid = 1'b1;
            req_grant_out[sel] = ch_req_grant_in;
        end
    end

    assign transfer = sel_found && ch_req_grant_in;
    assign push     = transfer && !req_in[sel].is_write;

    // Route the channel response to the head-tag owner, or drain it as an orphan.
    always_comb begin
        for (int j = 0; j < NUM_REQ; j++) begin
            resp_out[j].valid = 1'b0;
            resp_out[j].data  = ch_resp_in.data;
        end
        ch_resp_grant_out = 1'b0;
        pop               = 1'b0;
        orphan_seen       = 1'b0;
        if (!rst) begin
            if (!fifo_empty) begin
                resp_out[head_tag] = ch_resp_in;
                ch_resp_grant_out  = resp_grant_in[head_tag];
                pop                = ch_resp_in.valid && resp_grant_in[head_tag];
            end else if (ch_resp_in.valid) begin
                ch_resp_grant_out = 1'b1;
                orphan_seen       = 1'b1;
            end
        end
    end

    // Next-state for the pointer, tag FIFO, counters and orphan flag.
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        tag_mem_d     = tag_mem_q;
        head_d        = head_q;
        tail_d        = tail_q;
        outstanding_d = outstanding_q;
        orphan_err_d  = orphan_err_q | orphan_seen;
        inc           = 1'b0;
        dec           = 1'b0;
        if (transfer) begin
            rr_ptr_d = (sel == sel_t'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
        end
        if (push) begin
            tag_mem_d[tail_q] = sel;
            tail_d            = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        for (int i = 0; i < NUM_REQ; i++) begin
            inc = push && (sel == sel_t'(i));
            dec = pop && (head_tag == sel_t'(i));
            if (inc && !dec && outstanding_q[i] != CNT_MAX) begin
                outstanding_d[i] = outstanding_q[i] + 1'b1;
            end else if (dec && !inc && outstanding_q[i] != '0) begin
                outstanding_d[i] = outstanding_q[i] - 1'b1;
            end
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            orphan_err_q <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                outstanding_q[i] <= '0;
            end
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            orphan_err_q  <= orphan_err_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Tag storage needs no reset; head/tail/count define which entries are live.
    always_ff @(posedge clk) begin
        tag_mem_q <= tag_mem_d;
    end

    assign outstanding = outstanding_q;
    assign orphan_err  = orphan_err_q;

endmodule
